// File: rtl/dmem_port_monitor.sv
// dmem_port_monitor: passive CPU data-port monitor emitting one transaction record per completed access
module dmem_port_monitor #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      mem_address,
  input  logic [3:0]       mem_byte_enable,
  input  logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_resp,
  output logic             dmem_valid,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_rdata,
  output logic             write,
  output logic [3:0]       wmask,
  output logic [31:0]      wdata,
  output logic             protocol_error,
  output logic             timeout,
  output logic             err_sticky,
  output logic [CNT_W-1:0] read_count,
  output logic [CNT_W-1:0] write_count
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             cap_read_q;
  logic [31:0]      cap_addr_q, cap_wdata_q;
  logic [3:0]       cap_be_q;
  logic             valid_q, write_q, perr_q, perr_d, to_q, sticky_q;
  logic [31:0]      addr_q, rdata_q, wdata_q;
  logic [3:0]       wmask_q;
  logic [CNT_W-1:0] rcnt_q, wcnt_q;

  logic        idle, req_any, req_one, req_both, mism, drop, to_hit, capture;
  logic        emit_live, emit, rec_read;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_be;

  // Classify the current cycle: capture, completion, violations and timeout
  always_comb begin
    idle      = state_q == IDLE;
    req_any   = mem_read | mem_write;
    req_one   = mem_read ^ mem_write;
    req_both  = mem_read & mem_write;
    mism      = !idle & req_any & ((mem_read != cap_read_q) | (mem_write == cap_read_q)
                | (mem_address != cap_addr_q)
                | (!cap_read_q & ((mem_byte_enable != cap_be_q) | (mem_wdata != cap_wdata_q))));
    drop      = !idle & !mem_resp & !req_any;
    to_hit    = !idle & !mem_resp & req_any & (wait_q == WW'(TIMEOUT));
    capture   = idle & req_one & !mem_resp;
    emit_live = idle & req_one & mem_resp;
    emit      = emit_live | (!idle & mem_resp);
    rec_read  = emit_live ? mem_read : cap_read_q;
    rec_addr  = emit_live ? mem_address : cap_addr_q;
    rec_be    = emit_live ? mem_byte_enable : cap_be_q;
    rec_wdata = emit_live ? mem_wdata : cap_wdata_q;
    perr_d    = idle ? (req_both | (mem_resp & !req_any)) : (mism | drop);
    state_d   = capture ? PENDING : (!idle & (mem_resp | drop | to_hit)) ? IDLE : state_q;
    wait_d    = capture ? WW'(1) : !idle ? wait_q + WW'(1) : wait_q;
  end

  // FSM, request capture and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      cap_read_q  <= 1'b0;
      cap_addr_q  <= '0;
      cap_be_q    <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (capture) begin
        cap_read_q  <= mem_read;
        cap_addr_q  <= mem_address;
        cap_be_q    <= mem_byte_enable;
        cap_wdata_q <= mem_wdata;
      end
    end
  end

  // Registered record, error pulses and transaction counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      rdata_q  <= '0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      perr_q   <= 1'b0;
      to_q     <= 1'b0;
      sticky_q <= 1'b0;
      rcnt_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      valid_q  <= emit & rec_read;
      write_q  <= emit & !rec_read;
      perr_q   <= perr_d;
      to_q     <= to_hit;
      sticky_q <= sticky_q | perr_d | to_hit;
      if (emit) addr_q <= rec_addr & 32'hFFFF_FFFC;
      if (emit & rec_read) begin
        rdata_q <= mem_rdata;
        wmask_q <= '0;
        rcnt_q  <= rcnt_q + CNT_W'(1);
      end
      if (emit & !rec_read) begin
        wmask_q <= rec_be;
        wdata_q <= rec_wdata;
        wcnt_q  <= wcnt_q + CNT_W'(1);
      end
    end
  end

  assign dmem_valid     = valid_q;
  assign dmem_addr      = addr_q;
  assign dmem_rdata     = rdata_q;
  assign write          = write_q;
  assign wmask          = wmask_q;
  assign wdata          = wdata_q;
  assign protocol_error = perr_q;
  assign timeout        = to_q;
  assign err_sticky     = sticky_q;
  assign read_count     = rcnt_q;
  assign write_count    = wcnt_q;
endmodule

// File: tb/tb_dmem_port_monitor.sv
// tb_dmem_port_monitor: directed self-checking bench for dmem_port_monitor
module tb_dmem_port_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_resp = 1'b0;
  logic [31:0] mem_address = '0, mem_wdata = '0, mem_rdata = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic        dmem_valid, write, protocol_error, timeout, err_sticky;
  logic [31:0] dmem_addr, dmem_rdata, wdata, read_count, write_count;
  logic [3:0]  wmask;
  int checks = 0;
  int errors = 0;

  dmem_port_monitor #(.TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata), .write(write), .wmask(wmask), .wdata(wdata),
    .protocol_error(protocol_error), .timeout(timeout), .err_sticky(err_sticky),
    .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    mem_read = 0; mem_write = 0; mem_resp = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", 32'(dmem_valid), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_rcnt", read_count, 0);
    chk("rst_perr", 32'(protocol_error), 0);
    rst_n = 1;
    tick();
    mem_read = 1; mem_address = 32'h64;
    tick(); tick(); tick();
    chk("rd_wait_valid", 32'(dmem_valid), 0);
    mem_resp = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    idle_in();
    chk("rd_valid", 32'(dmem_valid), 1);
    chk("rd_addr", dmem_addr, 32'h64);
    chk("rd_rdata", dmem_rdata, 32'hDEADBEEF);
    chk("rd_write", 32'(write), 0);
    chk("rd_wmask", 32'(wmask), 0);
    chk("rd_rcnt", read_count, 1);
    chk("rd_perr", 32'(protocol_error), 0);
    tick();
    chk("rd_pulse_end", 32'(dmem_valid), 0);
    chk("rd_addr_hold", dmem_addr, 32'h64);
    mem_write = 1; mem_address = 32'h102; mem_byte_enable = 4'b0110; mem_wdata = 32'h11223344; mem_resp = 1;
    tick();
    idle_in();
    chk("wr_write", 32'(write), 1);
    chk("wr_addr", dmem_addr, 32'h100);
    chk("wr_wmask", 32'(wmask), 32'h6);
    chk("wr_wdata", wdata, 32'h11223344);
    chk("wr_valid", 32'(dmem_valid), 0);
    chk("wr_wcnt", write_count, 1);
    chk("wr_rdata_hold", dmem_rdata, 32'hDEADBEEF);
    chk("wr_sticky0", 32'(err_sticky), 0);
    tick();
    mem_read = 1; mem_address = 32'h40;
    tick();
    mem_address = 32'h44;
    tick();
    chk("mm_perr", 32'(protocol_error), 1);
    chk("mm_sticky", 32'(err_sticky), 1);
    mem_address = 32'h40;
    tick();
    chk("mm_perr_once", 32'(protocol_error), 0);
    mem_resp = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    idle_in();
    chk("mm_valid", 32'(dmem_valid), 1);
    chk("mm_addr", dmem_addr, 32'h40);
    chk("mm_rdata", dmem_rdata, 32'hCAFEF00D);
    chk("mm_rcnt", read_count, 2);
    mem_read = 1; mem_address = 32'h13; mem_rdata = 32'h0000_1234; mem_resp = 1;
    tick();
    mem_read = 0; mem_write = 1; mem_address = 32'h20; mem_byte_enable = 4'hF; mem_wdata = 32'hA5A5_5A5A;
    chk("b2b_rd_valid", 32'(dmem_valid), 1);
    chk("b2b_rd_addr", dmem_addr, 32'h10);
    tick();
    idle_in();
    chk("b2b_wr_write", 32'(write), 1);
    chk("b2b_wr_valid", 32'(dmem_valid), 0);
    chk("b2b_wr_wmask", 32'(wmask), 32'hF);
    chk("b2b_wr_addr", dmem_addr, 32'h20);
    chk("b2b_rcnt", read_count, 3);
    chk("b2b_wcnt", write_count, 2);
    mem_read = 1; mem_address = 32'h80;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("to_early", 32'(timeout), 0);
    tick();
    chk("to_pulse", 32'(timeout), 1);
    mem_read = 0; mem_resp = 1;
    tick();
    idle_in();
    chk("to_pulse_end", 32'(timeout), 0);
    chk("to_spurious", 32'(protocol_error), 1);
    chk("to_no_rec", 32'(dmem_valid), 0);
    mem_read = 1; mem_write = 1; mem_address = 32'h90;
    tick();
    idle_in();
    chk("both_perr", 32'(protocol_error), 1);
    tick();
    chk("both_perr_end", 32'(protocol_error), 0);
    mem_resp = 1;
    tick();
    idle_in();
    chk("spur_perr", 32'(protocol_error), 1);
    chk("spur_valid", 32'(dmem_valid), 0);
    chk("spur_write", 32'(write), 0);
    chk("spur_rcnt", read_count, 3);
    chk("spur_wcnt", write_count, 2);
    mem_read = 1; mem_address = 32'h200;
    tick();
    rst_n = 0;
    #1;
    chk("mr_valid", 32'(dmem_valid), 0);
    chk("mr_addr", dmem_addr, 0);
    chk("mr_sticky", 32'(err_sticky), 0);
    chk("mr_rcnt", read_count, 0);
    chk("mr_wdata", wdata, 0);
    idle_in();
    tick();
    rst_n = 1;
    tick();
    chk("mr_no_rec", 32'(dmem_valid), 0);
    mem_read = 1; mem_address = 32'h300;
    tick();
    mem_resp = 1; mem_rdata = 32'h0BAD_F00D;
    tick();
    idle_in();
    chk("mr_next_valid", 32'(dmem_valid), 1);
    chk("mr_next_addr", dmem_addr, 32'h300);
    chk("mr_next_rcnt", read_count, 1);
    chk("mr_next_perr", 32'(protocol_error), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
